bitstream_merger: RTL and testbench

//  Sits directly downstream of channelpacker. Packs its variable-length, MSB-aligned

---
 rtl/bitstream_merger.sv | 108 ++++++++++
 tb/tb_bitstream_merger.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_merger.sv
// rtl/bitstream_merger.sv - packs MSB-aligned variable-length bitfields into 64-bit MSB-first words
// Optional BITMERGE_BYTECNT_EN adds o_total, a running count of emitted valid bytes.
module bitstream_merger (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vl,
  input  logic [62:0] i_bv,
  input  logic [5:0]  i_bc,
  input  logic        i_flush,
  output logic        o_vl,
  output logic [63:0] o_data,
  output logic [3:0]  o_nbytes,
  output logic        o_last,
`ifdef BITMERGE_BYTECNT_EN
  output logic [31:0] o_total,
`endif
  output logic        o_busy
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]   state, nxt_state;
  logic [126:0] acc, acc_app, nxt_acc;
  logic [6:0]   cnt, cnt_app, nxt_cnt, rem_src;
  logic [62:0]  payload;
  logic         nxt_vl, nxt_last;
  logic [63:0]  nxt_data;
  logic [3:0]   nxt_nbytes;

  // Bits below the payload are masked so acc stays zero beyond cnt.
  assign payload = i_bv & ~({63{1'b1}} >> i_bc);
  assign o_busy  = (state == ST_FLUSH);

  always_comb begin
    acc_app = acc;
    cnt_app = cnt;
    if (state == ST_RUN && i_vl) begin
      acc_app = acc | ({payload, 64'd0} >> cnt);
      cnt_app = cnt + {1'b0, i_bc};
    end
  end

  // Remainder length: held count in FLUSH, post-append count in RUN (only used when < 64).
  assign rem_src = (state == ST_FLUSH) ? cnt : cnt_app;

  always_comb begin
    nxt_state  = ST_RUN;
    nxt_acc    = acc_app;
    nxt_cnt    = cnt_app;
    nxt_vl     = 1'b0;
    nxt_data   = 64'd0;
    nxt_nbytes = 4'd0;
    nxt_last   = 1'b0;
    if (state == ST_FLUSH) begin
      nxt_vl     = 1'b1;
      nxt_data   = acc[126:63];
      nxt_nbytes = 4'((rem_src + 7'd7) >> 3);
      nxt_last   = 1'b1;
      nxt_acc    = '0;
      nxt_cnt    = 7'd0;
    end else if (cnt_app >= 7'd64) begin
      nxt_vl     = 1'b1;
      nxt_data   = acc_app[126:63];
      nxt_nbytes = 4'd8;
      nxt_acc    = acc_app << 64;
      nxt_cnt    = cnt_app - 7'd64;
      if (i_flush) nxt_state = ST_FLUSH;
    end else if (i_flush) begin
      nxt_vl     = 1'b1;
      nxt_data   = acc_app[126:63];
      nxt_nbytes = 4'((rem_src + 7'd7) >> 3);
      nxt_last   = 1'b1;
      nxt_acc    = '0;
      nxt_cnt    = 7'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      acc      <= '0;
      cnt      <= 7'd0;
      o_vl     <= 1'b0;
      o_data   <= 64'd0;
      o_nbytes <= 4'd0;
      o_last   <= 1'b0;
    end else begin
      state    <= nxt_state;
      acc      <= nxt_acc;
      cnt      <= nxt_cnt;
      o_vl     <= nxt_vl;
      o_data   <= nxt_data;
      o_nbytes <= nxt_nbytes;
      o_last   <= nxt_last;
    end
  end

`ifdef BITMERGE_BYTECNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      o_total <= 32'd0;
    else if (nxt_vl)
      o_total <= o_total + {28'd0, nxt_nbytes};
  end
`endif

endmodule

// File: tb/tb_bitstream_merger.sv
// tb/tb_bitstream_merger.sv - self-checking bench for bitstream_merger
// Honours BITMERGE_BYTECNT_EN to also check o_total.
module tb_bitstream_merger;

  logic        clk = 1'b0;
  logic        rst, i_vl, i_flush;
  logic [62:0] i_bv;
  logic [5:0]  i_bc;
  logic        o_vl, o_last, o_busy;
  logic [63:0] o_data;
  logic [3:0]  o_nbytes;
`ifdef BITMERGE_BYTECNT_EN
  logic [31:0] o_total;
  logic [31:0] exp_tot;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bitstream_merger dut (
    .clk      (clk),
    .rst      (rst),
    .i_vl     (i_vl),
    .i_bv     (i_bv),
    .i_bc     (i_bc),
    .i_flush  (i_flush),
    .o_vl     (o_vl),
    .o_data   (o_data),
    .o_nbytes (o_nbytes),
    .o_last   (o_last),
`ifdef BITMERGE_BYTECNT_EN
    .o_total  (o_total),
`endif
    .o_busy   (o_busy)
  );

  typedef struct {
    logic        vl;
    logic [62:0] bv;
    logic [5:0]  bc;
    logic        flush;
    logic        evl;
    logic [63:0] edata;
    logic [3:0]  enb;
    logic        elast;
    logic        ebusy;
  } vec_t;

  localparam logic [62:0] ONES63 = {63{1'b1}};
  localparam logic [63:0] ONES64 = {64{1'b1}};
  localparam logic [63:0] REM62  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [62:0] A5BV   = {8'hA5, 55'd0};
  localparam logic [62:0] BIT62  = {1'b1, 62'd0};

  vec_t tbl[13];

  // Reference model: a plain bit queue in stream order.
  bit q[$];
  bit m_flushing;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic evl, input logic [63:0] ed,
                         input logic [3:0] en, input logic el, input logic eb);
    chk(nm, {57'd0, o_vl, o_data, o_nbytes, o_last, o_busy}, {57'd0, evl, ed, en, el, eb});
`ifdef BITMERGE_BYTECNT_EN
    if (evl) exp_tot = exp_tot + {28'd0, en};
    chk({nm, "_total"}, {96'd0, o_total}, {96'd0, exp_tot});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vl, input logic [62:0] bv, input logic [5:0] bc, input logic fl);
    i_vl = vl; i_bv = bv; i_bc = bc; i_flush = fl;
  endtask

  task automatic model_step(input logic vl, input logic [62:0] bv, input logic [5:0] bc,
                            input logic fl, output logic evl, output logic [63:0] ed,
                            output logic [3:0] en, output logic el, output logic eb);
    bit do_rem;
    int r;
    evl = 0; ed = '0; en = 0; el = 0; do_rem = 0;
    if (m_flushing) begin
      m_flushing = 0;
      do_rem = 1;
    end else begin
      if (vl) for (int k = 0; k < int'(bc); k++) q.push_back(bv[62-k]);
      if (q.size() >= 64) begin
        for (int k = 0; k < 64; k++) ed[63-k] = q.pop_front();
        evl = 1; en = 8;
        if (fl) m_flushing = 1;
      end else if (fl) begin
        do_rem = 1;
      end
    end
    if (do_rem) begin
      r = q.size();
      for (int k = 0; k < r; k++) ed[63-k] = q.pop_front();
      evl = 1; el = 1; en = 4'((r + 7) / 8);
    end
    eb = m_flushing;
  endtask

  initial begin
    logic        evl, el, eb;
    logic [63:0] ed;
    logic [3:0]  en;
    logic [63:0] rnd;
    logic        rv, rf;
    logic [5:0]  rbc;

    tbl[0]  = '{1'b1, A5BV,   6'd8,  1'b1, 1'b1, 64'hA500_0000_0000_0000, 4'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 63'd0,  6'd0,  1'b1, 1'b1, 64'd0,                   4'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, ONES63, 6'd63, 1'b0, 1'b0, 64'd0,                   4'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, ONES63, 6'd63, 1'b0, 1'b1, ONES64,                  4'd8, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 63'd0,  6'd0,  1'b1, 1'b1, REM62,                   4'd8, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, ONES63, 6'd4,  1'b1, 1'b1, 64'hF000_0000_0000_0000, 4'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, ONES63, 6'd0,  1'b1, 1'b1, 64'd0,                   4'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, ONES63, 6'd63, 1'b0, 1'b0, 64'd0,                   4'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, ONES63, 6'd63, 1'b1, 1'b1, ONES64,                  4'd8, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, ONES63, 6'd63, 1'b1, 1'b1, REM62,                   4'd8, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 63'd0,  6'd0,  1'b0, 1'b0, 64'd0,                   4'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 63'd0,  6'd0,  1'b1, 1'b1, 64'd0,                   4'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, ONES63, 6'd9,  1'b1, 1'b1, 64'hFF80_0000_0000_0000, 4'd2, 1'b1, 1'b0};

    rst = 1'b1;
    drive(1'b0, 63'd0, 6'd0, 1'b0);
`ifdef BITMERGE_BYTECNT_EN
    exp_tot = 32'd0;
`endif
    tick();
    tick();
    chk_out("reset", 1'b0, 64'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].vl, tbl[i].bv, tbl[i].bc, tbl[i].flush);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].evl, tbl[i].edata, tbl[i].enb, tbl[i].elast, tbl[i].ebusy);
    end

    for (int i = 0; i < 64; i++) begin
      drive(1'b1, BIT62, 6'd1, 1'b0);
      tick();
      if (i < 63) chk_out("single_bits_idle", 1'b0, 64'd0, 4'd0, 1'b0, 1'b0);
      else        chk_out("single_bits_word", 1'b1, ONES64, 4'd8, 1'b0, 1'b0);
    end
    drive(1'b0, 63'd0, 6'd0, 1'b0);
    tick();
    chk_out("single_bits_after", 1'b0, 64'd0, 4'd0, 1'b0, 1'b0);

    drive(1'b1, ONES63, 6'd40, 1'b0);
    tick();
    chk_out("midframe_fill", 1'b0, 64'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 63'd0, 6'd0, 1'b0);
    rst = 1'b1;
    tick();
`ifdef BITMERGE_BYTECNT_EN
    exp_tot = 32'd0;
`endif
    chk_out("midframe_reset", 1'b0, 64'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 63'd0, 6'd0, 1'b1);
    tick();
    chk_out("post_reset_flush", 1'b1, 64'd0, 4'd0, 1'b1, 1'b0);

    q.delete();
    m_flushing = 0;
    for (int c = 0; c < 3000; c++) begin
      rnd = {$urandom, $urandom};
      rv  = ($urandom % 4) != 0;
      rbc = 6'($urandom_range(0, 63));
      rf  = ($urandom % 12) == 0;
      drive(rv, rnd[62:0], rbc, rf);
      if (($urandom % 400) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        m_flushing = 0;
`ifdef BITMERGE_BYTECNT_EN
        exp_tot = 32'd0;
`endif
        chk_out("rand_reset", 1'b0, 64'd0, 4'd0, 1'b0, 1'b0);
      end else begin
        model_step(rv, rnd[62:0], rbc, rf, evl, ed, en, el, eb);
        tick();
        chk_out("rand", evl, ed, en, el, eb);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
